// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the NOTI frame parser.
//   state_e    : parser FSM states
//   err_code_e : abort cause reported on err_code
//   ASCII_*    : delimiter bytes, TAG_STR holds the "NOTI" tag
//   tag_char() : returns the expected tag byte for a tag index
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TAG    = 3'd1,
    ST_SEP1   = 3'd2,
    ST_HANDLE = 3'd3,
    ST_SEP2   = 3'd4,
    ST_VALUE  = 3'd5,
    ST_TERM   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_TAG     = 3'd1,
    ERR_SEP     = 3'd2,
    ERR_HEX     = 3'd3,
    ERR_TERM    = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_code_e;

  localparam logic [7:0]  ASCII_PCT   = 8'h25;
  localparam logic [7:0]  ASCII_COMMA = 8'h2C;
  localparam logic [31:0] TAG_STR     = 32'h4E4F5449;
  localparam int          TAG_LEN     = 4;

  // Expected tag byte for a given position, first character first.
  function automatic logic [7:0] tag_char(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = TAG_STR[31:24];
      2'd1:    c = TAG_STR[23:16];
      2'd2:    c = TAG_STR[15:8];
      2'd3:    c = TAG_STR[7:0];
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hex_digit_decode.sv
// Combinational ASCII hex digit decoder.
//   i_byte   : ASCII byte
//   o_nibble : decoded value (0 when not a hex digit)
//   o_valid  : 1 for 0-9, A-F, a-f
module hex_digit_decode (
  input  logic [7:0] i_byte,
  output logic [3:0] o_nibble,
  output logic       o_valid
);

  // Map the three ASCII hex ranges onto 0..15.
  always_comb begin
    o_nibble = 4'h0;
    o_valid  = 1'b0;
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      o_nibble = i_byte[3:0];
      o_valid  = 1'b1;
    end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                 (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 yields 10.
      o_nibble = i_byte[3:0] + 4'd9;
      o_valid  = 1'b1;
    end else begin
      o_nibble = 4'h0;
      o_valid  = 1'b0;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses "%NOTI,<handle hex>,<value hex>%" frames from a byte stream.
//   clk, reset (async, active low)
//   byte_tick/byte_in  : one received byte per strobe
//   frame_tick         : pulse one cycle after the closing '%' of a good frame
//   handle/value       : last committed fields, first digit in the MSBs
//   err_tick/err_code  : pulse and cause of an aborted frame
//   frame_cnt/err_cnt  : good frames (wrapping), aborts (saturating)
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int HANDLE_DIGITS = 4,
  parameter int VALUE_DIGITS  = 8,
  parameter int TIMEOUT_CYC   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       byte_tick,
  input  logic [7:0]                 byte_in,
  output logic                       frame_tick,
  output logic [4*HANDLE_DIGITS-1:0] handle,
  output logic [4*VALUE_DIGITS-1:0]  value,
  output logic                       err_tick,
  output logic [2:0]                 err_code,
  output logic [15:0]                frame_cnt,
  output logic [7:0]                 err_cnt
);

  localparam int         HW       = 4 * HANDLE_DIGITS;
  localparam int         VW       = 4 * VALUE_DIGITS;
  localparam logic [4:0] TAG_LAST = 5'(TAG_LEN - 1);
  localparam logic [4:0] H_LAST   = 5'(HANDLE_DIGITS - 1);
  localparam logic [4:0] V_LAST   = 5'(VALUE_DIGITS - 1);

  if (HANDLE_DIGITS < 1 || HANDLE_DIGITS > 8) begin : g_bad_handle
    $error("HANDLE_DIGITS must be in 1..8");
  end
  if (VALUE_DIGITS < 1 || VALUE_DIGITS > 16) begin : g_bad_value
    $error("VALUE_DIGITS must be in 1..16");
  end
  if (TIMEOUT_CYC < 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be >= 0");
  end

  state_e          r_state, w_state_nxt;
  logic [4:0]      r_idx, w_idx_nxt;
  logic [HW-1:0]   r_work_h, r_handle;
  logic [VW-1:0]   r_work_v, r_value;
  logic            r_frame_tick, r_err_tick;
  err_code_e       r_err_code, w_abort_code;
  logic [15:0]     r_frame_cnt;
  logic [7:0]      r_err_cnt;
  logic            w_abort, w_commit, w_shift_h, w_shift_v, w_timeout;
  logic            w_is_pct, w_is_comma, w_hex_valid;
  logic [3:0]      w_nibble;

  hex_digit_decode u_hex (
    .i_byte   (byte_in),
    .o_nibble (w_nibble),
    .o_valid  (w_hex_valid)
  );

  assign w_is_pct   = (byte_in == ASCII_PCT);
  assign w_is_comma = (byte_in == ASCII_COMMA);

  if (TIMEOUT_CYC > 0) begin : g_timeout
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] r_to_cnt;

    // Idle-cycle counter inside a frame; restarts on every accepted byte.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_to_cnt <= '0;
      end else if (byte_tick || r_state == ST_IDLE || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end

    // Fires on the TIMEOUT_CYC-th consecutive cycle without a byte.
    assign w_timeout = (r_state != ST_IDLE) && !byte_tick &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  // Next-state and per-byte actions of the frame grammar.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_abort      = 1'b0;
    w_abort_code = ERR_NONE;
    w_commit     = 1'b0;
    w_shift_h    = 1'b0;
    w_shift_v    = 1'b0;
    if (byte_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_pct) begin
            w_state_nxt = ST_TAG;
            w_idx_nxt   = 5'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_TAG: begin
          if (byte_in == tag_char(r_idx[1:0])) begin
            if (r_idx == TAG_LAST) begin
              w_state_nxt = ST_SEP1;
              w_idx_nxt   = 5'd0;
            end else begin
              w_idx_nxt = r_idx + 5'd1;
            end
          end else begin
            w_abort      = 1'b1;
            w_abort_code = ERR_TAG;
          end
        end
        ST_SEP1, ST_SEP2: begin
          if (w_is_comma) begin
            w_state_nxt = (r_state == ST_SEP1) ? ST_HANDLE : ST_VALUE;
            w_idx_nxt   = 5'd0;
          end else begin
            w_abort      = 1'b1;
            w_abort_code = ERR_SEP;
          end
        end
        ST_HANDLE: begin
          if (w_hex_valid) begin
            w_shift_h = 1'b1;
            if (r_idx == H_LAST) begin
              w_state_nxt = ST_SEP2;
              w_idx_nxt   = 5'd0;
            end else begin
              w_idx_nxt = r_idx + 5'd1;
            end
          end else begin
            w_abort      = 1'b1;
            w_abort_code = ERR_HEX;
          end
        end
        ST_VALUE: begin
          if (w_hex_valid) begin
            w_shift_v = 1'b1;
            if (r_idx == V_LAST) begin
              w_state_nxt = ST_TERM;
              w_idx_nxt   = 5'd0;
            end else begin
              w_idx_nxt = r_idx + 5'd1;
            end
          end else begin
            w_abort      = 1'b1;
            w_abort_code = ERR_HEX;
          end
        end
        ST_TERM: begin
          if (w_is_pct) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 5'd0;
          end else begin
            w_abort      = 1'b1;
            w_abort_code = ERR_TERM;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 5'd0;
        end
      endcase
      // A '%' can only abort in TAG/SEP/digit slots (codes 1-3), and it
      // doubles as the start of the next frame, so resync onto the tag.
      if (w_abort) begin
        w_state_nxt = w_is_pct ? ST_TAG : ST_IDLE;
        w_idx_nxt   = 5'd0;
      end else begin
        w_idx_nxt = w_idx_nxt;
      end
    end else if (w_timeout) begin
      w_abort      = 1'b1;
      w_abort_code = ERR_TIMEOUT;
      w_state_nxt  = ST_IDLE;
      w_idx_nxt    = 5'd0;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, working registers, committed fields, pulses and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= 5'd0;
      r_work_h     <= '0;
      r_work_v     <= '0;
      r_handle     <= '0;
      r_value      <= '0;
      r_frame_tick <= 1'b0;
      r_err_tick   <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_frame_cnt  <= 16'd0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_tick <= w_commit;
      r_err_tick   <= w_abort;
      if (w_shift_h) begin
        r_work_h <= (r_work_h << 4'd4) | HW'(w_nibble);
      end
      if (w_shift_v) begin
        r_work_v <= (r_work_v << 4'd4) | VW'(w_nibble);
      end
      if (w_commit) begin
        r_handle    <= r_work_h;
        r_value     <= r_work_v;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_abort) begin
        r_err_code <= w_abort_code;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign frame_tick = r_frame_tick;
  assign err_tick   = r_err_tick;
  assign err_code   = r_err_code;
  assign handle     = r_handle;
  assign value      = r_value;
  assign frame_cnt  = r_frame_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter HANDLE_DIGITS, default 4: hex digits in handle field, legal 1..8.
REQ-002 Parameter VALUE_DIGITS, default 8: hex digits in value field, legal 1..16.
REQ-003 Parameter TIMEOUT_CYC, default 0: max clk cycles between accepted bytes inside a frame; 0 disables the timeout.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 byte_tick  in  1  one-cycle strobe; byte_in is valid (rx_done of uart_rx).
REQ-007 byte_in  in  8  received ASCII byte.
REQ-008 frame_tick  out  1  one-cycle pulse; a complete frame was parsed.
REQ-009 handle  out  4*HANDLE_DIGITS  parsed handle field, MSB = first digit.
REQ-010 value  out  4*VALUE_DIGITS  parsed value field, MSB = first digit.
REQ-011 err_tick  out  1  one-cycle pulse; current frame aborted.
REQ-012 err_code  out  3  cause of most recent abort.
REQ-013 frame_cnt  out  16  good frames since reset, wraps at 0xFFFF->0x0000.
REQ-014 err_cnt  out  8  aborted frames since reset, saturates at 0xFF.

Function
REQ-015 Frame grammar SHALL be '%' 'N' 'O' 'T' 'I' ',' HANDLE_DIGITS hex ',' VALUE_DIGITS hex '%'.
REQ-016 Hex digits SHALL accept 0-9, A-F, a-f; any other byte in a digit slot is an error.
REQ-017 FSM states: IDLE, TAG, SEP1, HANDLE, SEP2, VALUE, TERM; a digit counter indexes TAG/HANDLE/VALUE.
REQ-018 IDLE: '%' -> TAG (index 0); all other bytes ignored, no error.
REQ-019 TAG: expected tag char -> next index; after 'I' -> SEP1; mismatch -> abort code TAG (1).
REQ-020 SEP1/SEP2: ',' -> HANDLE/VALUE; else abort code SEP (2).
REQ-021 HANDLE/VALUE: valid digit shifts into a working register, 4 bits per digit; after last digit -> SEP2/TERM; invalid digit -> abort code HEX (3).
REQ-022 TERM: '%' -> commit working registers to handle/value, frame_tick=1 on the next cycle, frame_cnt+1, -> IDLE; else abort code TERM (4).
REQ-023 Timeout: if TIMEOUT_CYC>0 and state!=IDLE and TIMEOUT_CYC cycles elapse with no byte_tick, abort code TIMEOUT (5); counter clears on each byte_tick.
REQ-024 Abort: err_tick=1 on the next cycle, err_code updated, err_cnt+1 (saturating), -> IDLE; handle/value unchanged.
REQ-025 Abort caused by a '%' byte (codes 1-3) SHALL instead go to TAG index 0 (resync), still flagging the error.
REQ-026 Latency: frame_tick and err_tick SHALL assert exactly one cycle after the byte_tick that caused them; they are never asserted together.
REQ-027 Back-to-back: a '%' byte arriving on the cycle frame_tick is high SHALL start a new frame.
REQ-028 byte_tick high for consecutive cycles SHALL consume one byte per cycle.
REQ-029 handle/value SHALL hold their last committed values until the next good frame.

Reset
REQ-030 On reset low: state IDLE; frame_tick, err_tick 0; err_code 0; handle, value, frame_cnt, err_cnt, working registers, timeout counter 0.
REQ-031 Reset mid-frame SHALL discard the partial frame without err_tick.

Structure
REQ-032 Package uart_frame_pkg: state enum, err_code enum (NONE=0..TIMEOUT=5), ASCII constants '%' ',' and the tag "NOTI".
REQ-033 Sub-module hex_digit_decode: combinational byte -> 4-bit nibble + valid flag.
REQ-034 Parameter legality SHALL be checked at elaboration.

Verification
REQ-035 "%NOTI,002A,F1F2F3F4%" -> one frame_tick, handle=16'h002A, value=32'hF1F2F3F4, frame_cnt=1.
REQ-036 "%NOTI,002a,0102ab0c%" directly followed by "%NOTI,FFFF,00000000%" -> two frame_ticks, final handle=16'hFFFF, value=32'h0, frame_cnt=2.
REQ-037 "%NOTI,00G2,..." -> err_tick with err_code=3 one cycle after 'G', err_cnt=1, handle/value unchanged.
REQ-038 "%NOX%NOTI,0001,00000005%" -> err_code=1 at 'X', resync on the second '%', then frame_tick with handle=16'h0001, value=32'h5.
REQ-039 TIMEOUT_CYC=100: "%NOTI,00" then 100 idle cycles -> err_code=5, state IDLE.
REQ-040 reset low after "%NOTI,00" -> all outputs 0 and no err_tick; then a full good frame parses normally.
